// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port Ram between NUM_REQ requesters.
// Round-robin grant, a two-stage command/response pipeline, and read data
// routed back to the requester that issued it.
// Optional: define ARB_BURST_LOCK_EN to add the reqLock input, which lets a
// requester keep exclusive grant over a burst of accepts.
module ram_arbiter #(
    parameter int WORD_SIZE   = 16,
    parameter int LENGTH_SIZE = 784,
    parameter int NUM_REQ     = 3,
    localparam int ADR_SIZE   = $clog2(LENGTH_SIZE)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            reqValid,
    input  logic [NUM_REQ-1:0]            reqWr,
    input  logic [NUM_REQ*ADR_SIZE-1:0]   reqAdr,
    input  logic [NUM_REQ*WORD_SIZE-1:0]  reqData,
`ifdef ARB_BURST_LOCK_EN
    input  logic [NUM_REQ-1:0]            reqLock,
`endif
    output logic [NUM_REQ-1:0]            reqReady,
    output logic [NUM_REQ-1:0]            rspValid,
    output logic [WORD_SIZE-1:0]          rspData,
    output logic                          ramRd,
    output logic                          ramWr,
    output logic [ADR_SIZE-1:0]           ramAdr,
    output logic [WORD_SIZE-1:0]          ramDataIn,
    input  logic [WORD_SIZE-1:0]          ramDataOut
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [ADR_SIZE:0] LEN_LIMIT = (ADR_SIZE+1)'(LENGTH_SIZE);

    logic [PTR_W-1:0]     rrPtr;
    logic [PTR_W-1:0]     grantIdx;
    logic [PTR_W-1:0]     scanPtr;
    logic [PTR_W-1:0]     grantPlusOne;
    logic                 grantValid;
    logic                 grantWr;
    logic                 grantOob;
    logic [ADR_SIZE-1:0]  grantAdr;
    logic [WORD_SIZE-1:0] grantData;
    int                   scanIdx;

    logic                 s1RspPending;
    logic                 s1Oob;
    logic [PTR_W-1:0]     s1Tag;
    logic                 s2Valid;
    logic                 s2Oob;
    logic [PTR_W-1:0]     s2Tag;
    logic [WORD_SIZE-1:0] rspHold;

`ifdef ARB_BURST_LOCK_EN
    logic                 lockActive;
    logic                 grantLock;
    logic [PTR_W-1:0]     ptrPlusOne;
`endif

    // Round-robin scan starting at rrPtr; a locked owner sits at rrPtr, so it
    // wins first whenever it is still valid, which gives it exclusive grant.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        scanIdx    = 0;
        scanPtr    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scanIdx = int'(rrPtr) + k;
            if (scanIdx >= NUM_REQ) begin
                scanIdx = scanIdx - NUM_REQ;
            end
            scanPtr = PTR_W'(scanIdx);
            if (!grantValid && reqValid[scanPtr]) begin
                grantValid = 1'b1;
                grantIdx   = scanPtr;
            end
        end
        if (rst) begin
            grantValid = 1'b0;
        end
    end

    // Select the winner's command fields and build the one-hot ready vector.
    always_comb begin
        grantWr   = 1'b0;
        grantAdr  = '0;
        grantData = '0;
        reqReady  = '0;
`ifdef ARB_BURST_LOCK_EN
        grantLock = 1'b0;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(grantIdx) == i) begin
                grantWr   = reqWr[i];
                grantAdr  = reqAdr[i*ADR_SIZE +: ADR_SIZE];
                grantData = reqData[i*WORD_SIZE +: WORD_SIZE];
`ifdef ARB_BURST_LOCK_EN
                grantLock = reqLock[i];
`endif
            end
            reqReady[i] = grantValid && (int'(grantIdx) == i);
        end
        grantOob = ({1'b0, grantAdr} >= LEN_LIMIT);
    end

    // Modulo-NUM_REQ increments, written as explicit wraps so that
    // non-power-of-two requester counts return to 0 exactly.
    always_comb begin
        grantPlusOne = (int'(grantIdx) == NUM_REQ - 1) ? '0 : grantIdx + 1'b1;
`ifdef ARB_BURST_LOCK_EN
        ptrPlusOne   = (int'(rrPtr) == NUM_REQ - 1) ? '0 : rrPtr + 1'b1;
`endif
    end

    // Advance the round-robin pointer past the winner (or park it on a
    // locking winner); releasing a lock without an accept moves it past the owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            rrPtr <= '0;
`ifdef ARB_BURST_LOCK_EN
            lockActive <= 1'b0;
`endif
        end else if (grantValid) begin
`ifdef ARB_BURST_LOCK_EN
            if (grantLock) begin
                rrPtr      <= grantIdx;
                lockActive <= 1'b1;
            end else begin
                rrPtr      <= grantPlusOne;
                lockActive <= 1'b0;
            end
`else
            rrPtr <= grantPlusOne;
`endif
        end else begin
`ifdef ARB_BURST_LOCK_EN
            if (lockActive) begin
                rrPtr      <= ptrPlusOne;
                lockActive <= 1'b0;
            end
`endif
        end
    end

    // Two-stage pipeline: stage 1 drives the Ram port, stage 2 lines up with
    // the Ram's registered read data; out-of-range commands never strobe the Ram.
    always_ff @(posedge clk) begin
        if (rst) begin
            ramRd        <= 1'b0;
            ramWr        <= 1'b0;
            ramAdr       <= '0;
            ramDataIn    <= '0;
            s1RspPending <= 1'b0;
            s1Oob        <= 1'b0;
            s1Tag        <= '0;
            s2Valid      <= 1'b0;
            s2Oob        <= 1'b0;
            s2Tag        <= '0;
            rspHold      <= '0;
        end else begin
            ramRd        <= grantValid && !grantWr && !grantOob;
            ramWr        <= grantValid && grantWr && !grantOob;
            s1RspPending <= grantValid && !grantWr;
            s1Oob        <= grantOob;
            s1Tag        <= grantIdx;
            if (grantValid) begin
                ramAdr    <= grantAdr;
                ramDataIn <= grantData;
            end
            s2Valid      <= s1RspPending;
            s2Oob        <= s1Oob;
            s2Tag        <= s1Tag;
            rspHold      <= rspData;
        end
    end

    // Route read data to the issuing requester; hold the last value otherwise.
    always_comb begin
        rspValid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rspValid[i] = s2Valid && (int'(s2Tag) == i);
        end
        if (s2Valid) begin
            rspData = s2Oob ? '0 : ramDataOut;
        end else begin
            rspData = rspHold;
        end
    end

endmodule
